// File: rtl/dmem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_pkg                                                               |
// | Shared types, segment map and legality check for the dmem arbiter.    |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_e;

   localparam logic [15:0] SEG_DATA   = 16'h1000;
   localparam logic [15:0] SEG_STACK  = 16'h7fff;
   localparam logic [15:0] SEG_SERIAL = 16'hffff;
   localparam logic [1:0]  SIZE_WORD  = 2'b11;

   // Only full-word reads are supported; writes of any size go through.
   function automatic logic access_legal(input logic [15:0] seg,
                                         input logic        we,
                                         input logic [1:0]  size);
      logic seg_ok;
      seg_ok = (seg == SEG_DATA) || (seg == SEG_STACK) || (seg == SEG_SERIAL);
      return seg_ok && (we || (size == SIZE_WORD));
   endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_rr_pick                                                           |
// | Combinational two-way grant picker (round-robin or fixed priority).   |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module dmem_rr_pick
   import dmem_pkg::*;
(
   input  logic  req_a,
   input  logic  req_b,
   input  port_e last_grant,
   input  logic  force_b,
   input  logic  rr_mode,
   output logic  valid_o,
   output port_e grant_o
);

   always_comb begin
      valid_o = req_a | req_b;
      grant_o = PORT_A;
      if (req_a && req_b) begin
         if (rr_mode) begin
            if (last_grant == PORT_A) grant_o = PORT_B;
            else                      grant_o = PORT_A;
         end else if (force_b) begin
            grant_o = PORT_B;
         end
      end else if (req_b) begin
         grant_o = PORT_B;
      end
   end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_arbiter                                                           |
// | Serialises MEM-stage (A) and loader (B) accesses onto one data port.  |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int          RR_MODE      = 1,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        a_req_in,
   input  logic        a_we_in,
   input  logic [31:0] a_addr_in,
   input  logic [31:0] a_wdata_in,
   input  logic [1:0]  a_size_in,
   output logic        a_ack_out,
   output logic [31:0] a_rdata_out,
   output logic        a_err_out,
   input  logic        b_req_in,
   input  logic        b_we_in,
   input  logic [31:0] b_addr_in,
   input  logic [31:0] b_wdata_in,
   input  logic [1:0]  b_size_in,
   output logic        b_ack_out,
   output logic [31:0] b_rdata_out,
   output logic        b_err_out,
   output logic [31:0] mem_addr_out,
   output logic [31:0] mem_wdata_out,
   output logic [1:0]  mem_size_out,
   output logic        mem_re_out,
   output logic        mem_we_out,
   input  logic [31:0] mem_rdata_in
);

   localparam logic [7:0] STARVE_THRESH = 8'(STARVE_LIMIT);

   state_e      state_q;
   port_e       owner_q;
   port_e       last_grant_q;
   logic [7:0]  starve_q;
   logic [31:0] mem_addr_q;
   logic [31:0] mem_wdata_q;
   logic [1:0]  mem_size_q;
   logic        mem_re_q;
   logic        mem_we_q;
   logic        a_ack_q;
   logic        a_err_q;
   logic [31:0] a_rdata_q;
   logic        b_ack_q;
   logic        b_err_q;
   logic [31:0] b_rdata_q;

   logic        w_arb_a;
   logic        w_arb_b;
   logic        w_force_b;
   logic        w_rr_mode;
   logic        w_pick_valid;
   port_e       w_grant;
   logic        w_grant_b;
   logic        w_sel_we;
   logic [31:0] w_sel_addr;
   logic [31:0] w_sel_wdata;
   logic [1:0]  w_sel_size;
   logic        w_sel_legal;
   logic        w_xfer_legal;

   // Nothing arbitrates during ACCESS; in DONE only the non-owner competes.
   assign w_arb_a = a_req_in & ((state_q == IDLE) | ((state_q == DONE) & (owner_q == PORT_B)));
   assign w_arb_b = b_req_in & ((state_q == IDLE) | ((state_q == DONE) & (owner_q == PORT_A)));
   assign w_force_b = (starve_q >= STARVE_THRESH);
   assign w_rr_mode = (RR_MODE != 0);

   dmem_rr_pick u_pick (
      .req_a      (w_arb_a),
      .req_b      (w_arb_b),
      .last_grant (last_grant_q),
      .force_b    (w_force_b),
      .rr_mode    (w_rr_mode),
      .valid_o    (w_pick_valid),
      .grant_o    (w_grant)
   );

   assign w_grant_b   = w_pick_valid & (w_grant == PORT_B);
   assign w_sel_we    = (w_grant == PORT_B) ? b_we_in    : a_we_in;
   assign w_sel_addr  = (w_grant == PORT_B) ? b_addr_in  : a_addr_in;
   assign w_sel_wdata = (w_grant == PORT_B) ? b_wdata_in : a_wdata_in;
   assign w_sel_size  = (w_grant == PORT_B) ? b_size_in  : a_size_in;
   assign w_sel_legal = access_legal(w_sel_addr[31:16], w_sel_we, w_sel_size);
   // A legal access always raises exactly one strobe.
   assign w_xfer_legal = mem_re_q | mem_we_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         owner_q      <= PORT_A;
         last_grant_q <= PORT_B;
         starve_q     <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_size_q   <= '0;
         mem_re_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         a_ack_q      <= 1'b0;
         a_err_q      <= 1'b0;
         a_rdata_q    <= '0;
         b_ack_q      <= 1'b0;
         b_err_q      <= 1'b0;
         b_rdata_q    <= '0;
      end else begin
         a_ack_q <= 1'b0;
         b_ack_q <= 1'b0;

         if (w_grant_b)                          starve_q <= '0;
         else if (b_req_in && starve_q != 8'hff) starve_q <= starve_q + 8'd1;

         case (state_q)
            ACCESS: begin
               state_q     <= DONE;
               mem_addr_q  <= '0;
               mem_wdata_q <= '0;
               mem_size_q  <= '0;
               mem_re_q    <= 1'b0;
               mem_we_q    <= 1'b0;
               if (owner_q == PORT_A) begin
                  a_ack_q <= 1'b1;
                  a_err_q <= ~w_xfer_legal;
                  if (mem_re_q)           a_rdata_q <= mem_rdata_in;
                  else if (!w_xfer_legal) a_rdata_q <= '0;
               end else begin
                  b_ack_q <= 1'b1;
                  b_err_q <= ~w_xfer_legal;
                  if (mem_re_q)           b_rdata_q <= mem_rdata_in;
                  else if (!w_xfer_legal) b_rdata_q <= '0;
               end
            end
            default: begin
               if (w_pick_valid) begin
                  state_q      <= ACCESS;
                  owner_q      <= w_grant;
                  last_grant_q <= w_grant;
                  mem_addr_q   <= w_sel_addr;
                  mem_wdata_q  <= w_sel_wdata;
                  mem_size_q   <= w_sel_size;
                  mem_re_q     <= ~w_sel_we & w_sel_legal;
                  mem_we_q     <= w_sel_we & w_sel_legal;
               end else begin
                  state_q <= IDLE;
               end
            end
         endcase
      end
   end

   assign a_ack_out     = a_ack_q;
   assign a_rdata_out   = a_rdata_q;
   assign a_err_out     = a_err_q;
   assign b_ack_out     = b_ack_q;
   assign b_rdata_out   = b_rdata_q;
   assign b_err_out     = b_err_q;
   assign mem_addr_out  = mem_addr_q;
   assign mem_wdata_out = mem_wdata_q;
   assign mem_size_out  = mem_size_q;
   assign mem_re_out    = mem_re_q;
   assign mem_we_out    = mem_we_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dmem_arbiter                                                        |
// | Round-robin and fixed-priority arbiters checked against a model.      |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module tb_dmem_arbiter;

   localparam int FP_LIMIT = 3;

   typedef struct packed {
      logic        a_ack;
      logic [31:0] a_rdata;
      logic        a_err;
      logic        b_ack;
      logic [31:0] b_rdata;
      logic        b_err;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      logic [1:0]  mem_size;
      logic        mem_re;
      logic        mem_we;
   } obs_t;

   // phase: 0 idle, 1 memory cycle in progress, 2 completion cycle
   typedef struct packed {
      int   phase;
      int   owner;
      int   last;
      int   starve;
      logic we;
      logic ok;
      obs_t o;
   } mdl_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] rd_val = 32'h0;

   // [dut][port]; dut 0 is round-robin, dut 1 fixed priority; port 0 = A, 1 = B
   logic        rq   [2][2];
   logic        wen  [2][2];
   logic [31:0] adr  [2][2];
   logic [31:0] wd   [2][2];
   logic [1:0]  sz   [2][2];
   logic        ack  [2][2];
   logic [31:0] rdat [2][2];
   logic        err  [2][2];
   logic [31:0] maddr [2];
   logic [31:0] mwd   [2];
   logic [1:0]  msz   [2];
   logic        mre   [2];
   logic        mwe   [2];

   mdl_t mdl [2];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   re_cnt  [2];
   int   ack_cnt [2];

   always #5 clock = ~clock;

   dmem_arbiter #(.RR_MODE(1), .STARVE_LIMIT(8)) dut0 (
      .clock(clock), .reset(reset),
      .a_req_in(rq[0][0]), .a_we_in(wen[0][0]), .a_addr_in(adr[0][0]),
      .a_wdata_in(wd[0][0]), .a_size_in(sz[0][0]),
      .a_ack_out(ack[0][0]), .a_rdata_out(rdat[0][0]), .a_err_out(err[0][0]),
      .b_req_in(rq[0][1]), .b_we_in(wen[0][1]), .b_addr_in(adr[0][1]),
      .b_wdata_in(wd[0][1]), .b_size_in(sz[0][1]),
      .b_ack_out(ack[0][1]), .b_rdata_out(rdat[0][1]), .b_err_out(err[0][1]),
      .mem_addr_out(maddr[0]), .mem_wdata_out(mwd[0]), .mem_size_out(msz[0]),
      .mem_re_out(mre[0]), .mem_we_out(mwe[0]), .mem_rdata_in(rd_val)
   );

   dmem_arbiter #(.RR_MODE(0), .STARVE_LIMIT(FP_LIMIT)) dut1 (
      .clock(clock), .reset(reset),
      .a_req_in(rq[1][0]), .a_we_in(wen[1][0]), .a_addr_in(adr[1][0]),
      .a_wdata_in(wd[1][0]), .a_size_in(sz[1][0]),
      .a_ack_out(ack[1][0]), .a_rdata_out(rdat[1][0]), .a_err_out(err[1][0]),
      .b_req_in(rq[1][1]), .b_we_in(wen[1][1]), .b_addr_in(adr[1][1]),
      .b_wdata_in(wd[1][1]), .b_size_in(sz[1][1]),
      .b_ack_out(ack[1][1]), .b_rdata_out(rdat[1][1]), .b_err_out(err[1][1]),
      .mem_addr_out(maddr[1]), .mem_wdata_out(mwd[1]), .mem_size_out(msz[1]),
      .mem_re_out(mre[1]), .mem_we_out(mwe[1]), .mem_rdata_in(rd_val)
   );

   function automatic logic legal_m(input logic [31:0] a, input logic w, input logic [1:0] s);
      logic seg;
      seg = (a[31:16] == 16'h1000) || (a[31:16] == 16'h7fff) || (a[31:16] == 16'hffff);
      return seg && (w || (s == 2'b11));
   endfunction

   function automatic mdl_t model_reset();
      mdl_t m;
      m = '0;
      m.last = 1;
      return m;
   endfunction

   function automatic mdl_t step(input mdl_t m, input int d);
      logic cand [2];
      int   g;
      m.o.a_ack = 1'b0;  m.o.b_ack = 1'b0;
      m.o.mem_addr = '0; m.o.mem_wdata = '0; m.o.mem_size = '0;
      m.o.mem_re = 1'b0; m.o.mem_we = 1'b0;
      g = -1;
      if (m.phase == 1) begin
         m.phase = 2;
         if (m.owner == 0) begin
            m.o.a_ack = 1'b1;
            m.o.a_err = !m.ok;
            if (!m.ok)      m.o.a_rdata = '0;
            else if (!m.we) m.o.a_rdata = rd_val;
         end else begin
            m.o.b_ack = 1'b1;
            m.o.b_err = !m.ok;
            if (!m.ok)      m.o.b_rdata = '0;
            else if (!m.we) m.o.b_rdata = rd_val;
         end
      end else begin
         cand[0] = rq[d][0];
         cand[1] = rq[d][1];
         if (m.phase == 2) cand[m.owner] = 1'b0;
         if (cand[0] && cand[1]) begin
            if (d == 0) g = 1 - m.last;
            else        g = (m.starve >= FP_LIMIT) ? 1 : 0;
         end else if (cand[0]) g = 0;
         else if (cand[1])     g = 1;
         if (g < 0) m.phase = 0;
         else begin
            m.phase = 1;
            m.owner = g;
            m.last  = g;
            m.we    = wen[d][g];
            m.ok    = legal_m(adr[d][g], wen[d][g], sz[d][g]);
            m.o.mem_addr  = adr[d][g];
            m.o.mem_wdata = wd[d][g];
            m.o.mem_size  = sz[d][g];
            m.o.mem_re    = !m.we && m.ok;
            m.o.mem_we    = m.we && m.ok;
         end
      end
      if (g == 1)                           m.starve = 0;
      else if (rq[d][1] && m.starve < 255)  m.starve = m.starve + 1;
      return m;
   endfunction

   function automatic obs_t observe(input int d);
      obs_t o;
      o.a_ack = ack[d][0];  o.a_rdata = rdat[d][0]; o.a_err = err[d][0];
      o.b_ack = ack[d][1];  o.b_rdata = rdat[d][1]; o.b_err = err[d][1];
      o.mem_addr = maddr[d]; o.mem_wdata = mwd[d];  o.mem_size = msz[d];
      o.mem_re = mre[d];     o.mem_we = mwe[d];
      return o;
   endfunction

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(posedge clock or negedge reset) begin
      for (int d = 0; d < 2; d++)
         mdl[d] <= (!reset) ? model_reset() : step(mdl[d], d);
   end

   always @(negedge clock) begin
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("cycle t=%0t dut%0d", $time, d), observe(d), mdl[d].o);
         re_cnt[d]  <= re_cnt[d] + int'(mre[d]);
         ack_cnt[d] <= ack_cnt[d] + int'(ack[d][0]) + int'(ack[d][1]);
      end
   end

   // Called at posedge+1; holds the request until the ack, then drops it one cycle later.
   task automatic xact(input int d, input int p, input logic we, input logic [31:0] a,
                       input logic [31:0] wv, input logic [1:0] s,
                       output int lat, output logic [31:0] rv, output logic ev);
      int n;
      rq[d][p] = 1'b1; wen[d][p] = we; adr[d][p] = a; wd[d][p] = wv; sz[d][p] = s;
      lat = -1; rv = '0; ev = 1'b0; n = 0;
      while (n < 20 && lat < 0) begin
         @(posedge clock); #1;
         n++;
         if (ack[d][p]) begin
            lat = n; rv = rdat[d][p]; ev = err[d][p];
         end
      end
      if (lat < 0) begin
         n_cmp++; n_bad++;
         $display("FAIL ack timeout dut%0d port%0d: got none required within 20 cycles", d, p);
      end
      @(posedge clock); #1;
      rq[d][p] = 1'b0;
   endtask

   int          lat [2][2];
   logic [31:0] rv  [2][2];
   logic        ev  [2][2];
   int          fl  [3];
   int          snap [2];

   initial begin
      for (int d = 0; d < 2; d++) begin
         re_cnt[d] = 0; ack_cnt[d] = 0;
         for (int p = 0; p < 2; p++) begin
            rq[d][p] = 0; wen[d][p] = 0; adr[d][p] = 0; wd[d][p] = 0; sz[d][p] = 0;
         end
      end
      repeat (3) @(posedge clock);
      #1;
      for (int d = 0; d < 2; d++)
         chk($sformatf("reset outputs dut%0d", d), observe(d), '0);
      reset = 1'b1;

      // tie straight out of reset: A first, B right behind
      rd_val = 32'h0BAD_F00D;
      fork
         xact(0, 0, 1'b0, 32'h1000_0010, 32'h0, 2'b11, lat[0][0], rv[0][0], ev[0][0]);
         xact(0, 1, 1'b1, 32'h7fff_0020, 32'h1234, 2'b10, lat[0][1], rv[0][1], ev[0][1]);
         xact(1, 0, 1'b0, 32'h1000_0010, 32'h0, 2'b11, lat[1][0], rv[1][0], ev[1][0]);
         xact(1, 1, 1'b1, 32'h7fff_0020, 32'h1234, 2'b10, lat[1][1], rv[1][1], ev[1][1]);
      join
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("tie1 A latency dut%0d", d), lat[d][0], 2);
         chk($sformatf("tie1 B latency dut%0d", d), lat[d][1], 4);
         chk($sformatf("tie1 A rdata dut%0d", d), rv[d][0], 32'h0BAD_F00D);
      end

      // plain A read
      rd_val = 32'hDEAD_BEEF;
      snap[0] = re_cnt[0]; snap[1] = re_cnt[1];
      fork
         xact(0, 0, 1'b0, 32'h1000_0004, 32'h0, 2'b11, lat[0][0], rv[0][0], ev[0][0]);
         xact(1, 0, 1'b0, 32'h1000_0004, 32'h0, 2'b11, lat[1][0], rv[1][0], ev[1][0]);
      join
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("read latency dut%0d", d), lat[d][0], 2);
         chk($sformatf("read rdata dut%0d", d), rv[d][0], 32'hDEAD_BEEF);
         chk($sformatf("read err dut%0d", d), ev[d][0], 1'b0);
         chk($sformatf("read strobes dut%0d", d), re_cnt[d] - snap[d], 1);
      end

      // tie after an A grant: round-robin serves B first, fixed priority still A
      rd_val = 32'h5A5A_0001;
      fork
         xact(0, 0, 1'b0, 32'h1000_0100, 32'h0, 2'b11, lat[0][0], rv[0][0], ev[0][0]);
         xact(0, 1, 1'b0, 32'h1000_0200, 32'h0, 2'b11, lat[0][1], rv[0][1], ev[0][1]);
         xact(1, 0, 1'b0, 32'h1000_0100, 32'h0, 2'b11, lat[1][0], rv[1][0], ev[1][0]);
         xact(1, 1, 1'b0, 32'h1000_0200, 32'h0, 2'b11, lat[1][1], rv[1][1], ev[1][1]);
      join
      chk("tie2 rr B latency", lat[0][1], 2);
      chk("tie2 rr A latency", lat[0][0], 4);
      chk("tie2 fp A latency", lat[1][0], 2);
      chk("tie2 fp B latency", lat[1][1], 4);

      // fixed priority: A keeps renewing while B holds its request
      fork
         begin
            for (int k = 0; k < 3; k++)
               xact(1, 0, 1'b0, 32'h1000_0300 + 32'(k * 4), 32'h0, 2'b11, fl[k], rv[1][0], ev[1][0]);
         end
         xact(1, 1, 1'b0, 32'h7fff_0040, 32'h0, 2'b11, lat[1][1], rv[1][1], ev[1][1]);
      join
      chk("starve A1 latency", fl[0], 2);
      chk("starve B latency", lat[1][1], 4);
      chk("starve A2 latency", fl[1], 3);
      chk("starve A3 latency", fl[2], 2);

      // unmapped address and sub-word read: no strobe, err set, rdata zeroed
      snap[0] = re_cnt[0]; snap[1] = re_cnt[1];
      fork
         xact(0, 1, 1'b0, 32'h2000_0000, 32'h0, 2'b11, lat[0][1], rv[0][1], ev[0][1]);
         xact(1, 1, 1'b0, 32'h2000_0000, 32'h0, 2'b11, lat[1][1], rv[1][1], ev[1][1]);
      join
      fork
         xact(0, 0, 1'b0, 32'h7fff_0010, 32'h0, 2'b01, lat[0][0], rv[0][0], ev[0][0]);
         xact(1, 0, 1'b0, 32'h7fff_0010, 32'h0, 2'b01, lat[1][0], rv[1][0], ev[1][0]);
      join
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("unmapped err dut%0d", d), ev[d][1], 1'b1);
         chk($sformatf("unmapped rdata dut%0d", d), rv[d][1], 32'h0);
         chk($sformatf("subword err dut%0d", d), ev[d][0], 1'b1);
         chk($sformatf("illegal strobes dut%0d", d), re_cnt[d] - snap[d], 0);
      end

      // serial read fires exactly once although the request stays up through DONE
      rd_val = 32'h0000_0055;
      snap[0] = re_cnt[0]; snap[1] = re_cnt[1];
      fork
         xact(0, 0, 1'b0, 32'hffff_0004, 32'h0, 2'b11, lat[0][0], rv[0][0], ev[0][0]);
         xact(1, 0, 1'b0, 32'hffff_0004, 32'h0, 2'b11, lat[1][0], rv[1][0], ev[1][0]);
      join
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("serial strobes dut%0d", d), re_cnt[d] - snap[d], 1);
         chk($sformatf("serial rdata dut%0d", d), rv[d][0], 32'h55);
      end

      // reset during a write's memory cycle
      for (int d = 0; d < 2; d++) begin
         rq[d][0] = 1'b1; wen[d][0] = 1'b1; adr[d][0] = 32'h1000_0008;
         wd[d][0] = 32'h0000_CAFE; sz[d][0] = 2'b11;
      end
      @(posedge clock); #1;
      for (int d = 0; d < 2; d++) chk($sformatf("write strobe dut%0d", d), mwe[d], 1'b1);
      #1 reset = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("async drop we dut%0d", d), mwe[d], 1'b0);
         chk($sformatf("async drop addr dut%0d", d), maddr[d], 32'h0);
         rq[d][0] = 1'b0;
         snap[d] = ack_cnt[d];
      end
      repeat (3) @(posedge clock);
      #1;
      for (int d = 0; d < 2; d++) chk($sformatf("no ack after reset dut%0d", d), ack_cnt[d] - snap[d], 0);
      reset = 1'b1;

      rd_val = 32'h1111_2222;
      fork
         xact(0, 0, 1'b0, 32'h1000_0040, 32'h0, 2'b11, lat[0][0], rv[0][0], ev[0][0]);
         xact(0, 1, 1'b0, 32'h1000_0080, 32'h0, 2'b11, lat[0][1], rv[0][1], ev[0][1]);
         xact(1, 0, 1'b0, 32'h1000_0040, 32'h0, 2'b11, lat[1][0], rv[1][0], ev[1][0]);
         xact(1, 1, 1'b0, 32'h1000_0080, 32'h0, 2'b11, lat[1][1], rv[1][1], ev[1][1]);
      join
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("post-reset tie A latency dut%0d", d), lat[d][0], 2);
         chk($sformatf("post-reset tie B latency dut%0d", d), lat[d][1], 4);
      end

      repeat (2) @(posedge clock);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got no completion, required finish before 50000");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter in front of the single data_memory port. It shares that port between the pipeline MEM stage (port A) and a debug/loader master (port B).
- Each access is serialised into a one-cycle memory strobe, so serial MMIO read side-effects fire exactly once.
- The read result is registered. Unmapped addresses and unsupported read sizes are flagged.
- Sits between the MEM stage / loader and data_memory.

Parameters:
- RR_MODE, 1, 1 = round-robin between A and B; 0 = A has fixed priority.
- STARVE_LIMIT, 8, in fixed-priority mode, the number of consecutive cycles B may wait before it is forced to win; range 1..255.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- a_req_in  in  1  port A request, held until a_ack_out
- a_we_in  in  1  A write (1) / read (0)
- a_addr_in  in  32  A byte address
- a_wdata_in  in  32  A write data
- a_size_in  in  2  A access size
- a_ack_out  out  1  one-cycle completion pulse to A
- a_rdata_out  out  32  A read data, valid with a_ack_out
- a_err_out  out  1  A error, valid with a_ack_out
- b_req_in, b_we_in, b_addr_in, b_wdata_in, b_size_in, b_ack_out, b_rdata_out, b_err_out  same as A, for port B
- mem_addr_out  out  32  to data_memory addr_in
- mem_wdata_out  out  32  to writedata_in
- mem_size_out  out  2  to size_in
- mem_re_out  out  1  to re_in
- mem_we_out  out  1  to we_in
- mem_rdata_in  in  32  from readdata_out

Behaviour:
- Reset (reset low, async):
  - State IDLE, owner = none, last_grant = B, so A wins the first round-robin tie. starve_cnt = 0.
  - All outputs are 0: acks, errs, rdata, and mem_* strobes and buses.
- FSM states:
  - IDLE: if any request is valid, arbitrate, latch the owner, latch the owner's addr/wdata/size/we into registers, and go to ACCESS.
  - ACCESS: lasts exactly one cycle. The mem_* outputs are driven from the latched registers. mem_re_out = !we & legal; mem_we_out = we & legal. At the clock edge, capture mem_rdata_in (reads) into the owner's rdata register. Go to DONE.
  - DONE: pulse the owner's ack for one cycle, with rdata and err valid. Next state:
    - ACCESS if the non-owner's request is high; arbitrate it and latch it this cycle.
    - Otherwise IDLE.
- The owner's request is ignored in DONE; a requester may only drop or renew its request after its ack.
- Latency: request seen in IDLE -> ack 2 cycles later. Sustained alternating traffic completes one access every 2 cycles.
- mem_* outputs are 0 in IDLE and DONE, so no spurious serial reads or writes occur.
- Legality:
  - The address is legal if addr[31:16] ∈ {16'h1000, 16'h7fff, 16'hffff}.
  - A read is legal only if size == 2'b11; writes of any size pass through.
  - Illegal access: no mem strobe is issued, rdata = 0, err = 1 with the ack, and the FSM still takes the ACCESS and DONE cycles.
- Arbitration:
  - Round-robin: on a simultaneous request, grant the port that is not last_grant. Update last_grant on every grant.
  - Fixed-priority: A wins ties. starve_cnt increments each cycle B's request is high and B is not granted, and clears when B is granted. When starve_cnt ≥ STARVE_LIMIT, B wins the next arbitration.
  - A lone requester always wins.
- Each requester's rdata_out and err_out hold their value until that port's next ack.
- A request dropped before its ack is a protocol violation; the latched access still completes and the ack still pulses.
- Reset asserted mid-ACCESS: the strobe is dropped immediately (async) and no ack is issued.

Decomposition:
- Shared package dmem_pkg holds:
  - state encodings (IDLE, ACCESS, DONE)
  - segment constants SEG_DATA = 16'h1000, SEG_STACK = 16'h7fff, SEG_SERIAL = 16'hffff
  - SIZE_WORD = 2'b11
- One sub-module, dmem_rr_pick: a combinational two-way grant picker with inputs req_a, req_b, last_grant, force_b, rr_mode.

Test Plan:
- A reads 0x10000004 while memory returns 0xDEADBEEF -> a single mem_re pulse in ACCESS; a_ack 2 cycles after the request with a_rdata = 0xDEADBEEF, a_err = 0.
- A and B request in the same cycle from reset, RR_MODE = 1 -> A is served first and B's ACCESS immediately follows A's DONE. Repeat the tie -> B is served first.
- RR_MODE = 0, STARVE_LIMIT = 3, A requests continuously and B holds its request -> B is granted after waiting ≥ 3 cycles, then A resumes.
- B reads 0x20000000 -> mem_re never asserts; b_ack with b_rdata = 0, b_err = 1. A read of 0x7fff0010 with size 2'b01 -> err = 1, no strobe.
- A reads 0xffff0004 (serial) -> exactly one mem_re_out cycle, even though a_req stays high through DONE.
- Reset driven low during ACCESS -> mem_we_out falls asynchronously; no ack; after release, A wins the first round-robin tie.
